// File: rtl/bjack_pkg.sv
// Shared constants and types for the blackjack card shoe: rank geometry,
// per-rank starting counts and the dealer FSM encoding.
package bjack_pkg;

    localparam int RANKS     = 10;
    localparam int DECK_SIZE = 52;
    localparam int CARD_W    = 4;
    localparam int CNT_W     = 5;

    typedef logic [CNT_W-1:0] cnt_t;

    // Index 8 covers 10/J/Q/K, index 9 is the ace.
    localparam cnt_t INIT_CNT [RANKS] = '{
        5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd16, 5'd4
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAW    = 2'd1,
        SEARCH  = 2'd2,
        PRESENT = 2'd3
    } dealer_state_e;

endpackage

// File: rtl/bjack_lfsr8.sv
// Free-running 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1; advances every cycle.
// Latency: output is the registered state. No backpressure; never stalls.
module bjack_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       SYS_CLK,
    input  logic       GEN_RES,
    output logic [7:0] lfsr_o
);

    // Right-shifting Galois form: feedback bit 0 XORs into taps 8,6,5,4.
    localparam logic [7:0] TAPS = 8'hB8;

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[7:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ TAPS;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (GEN_RES) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/bjack_dealer.sv
// Card shoe: one card drawn without replacement per NEXT_C rising edge, 3..12 cycles to CARD_VLD.
// Requests arriving while BUSY are dropped, not queued.
// BJACK_DEALER_AUTOFILL_EN: a request on an empty shoe restocks and draws instead of being ignored.
import bjack_pkg::*;

module bjack_dealer #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic              SYS_CLK,
    input  logic              GEN_RES,
    input  logic              NEW_G,
    input  logic              NEXT_C,
    output logic [CARD_W-1:0] CARD,
    output logic              CARD_VLD,
    output logic              BUSY,
    output logic              EMPTY,
    output logic [5:0]        LEFT
);

    dealer_state_e     state_q, state_d;
    logic              next_c_q;
    logic              req_edge;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        draw_idx;
    cnt_t              cnt_q [RANKS];
    cnt_t              cnt_d [RANKS];
    logic [5:0]        left_q, left_d;
    logic              empty_q, empty_d;
    logic [CARD_W-1:0] card_q, card_d;
    logic [7:0]        lfsr_w;
    logic              lfsr_unused;

    bjack_lfsr8 #(.SEED(SEED)) u_lfsr (
        .SYS_CLK (SYS_CLK),
        .GEN_RES (GEN_RES),
        .lfsr_o  (lfsr_w)
    );

    assign lfsr_unused = ^lfsr_w[7:4];
    assign req_edge    = NEXT_C & ~next_c_q;
    assign draw_idx    = (lfsr_w[3:0] >= 4'd10) ? (lfsr_w[3:0] - 4'd10) : lfsr_w[3:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        empty_d = empty_q;
        card_d  = card_q;

        if (NEW_G) begin
            cnt_d   = INIT_CNT;
            left_d  = 6'(DECK_SIZE);
            empty_d = 1'b0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_edge) begin
                        if (!empty_q) begin
                            state_d = DRAW;
                        end else begin
`ifdef BJACK_DEALER_AUTOFILL_EN
                            cnt_d   = INIT_CNT;
                            left_d  = 6'(DECK_SIZE);
                            empty_d = 1'b0;
                            state_d = DRAW;
`endif
                        end
                    end
                end
                DRAW: begin
                    idx_d   = draw_idx;
                    state_d = SEARCH;
                end
                SEARCH: begin
                    // Guaranteed to find a card: DRAW is only entered with LEFT > 0.
                    if (cnt_q[idx_q] != '0) begin
                        cnt_d[idx_q] = cnt_q[idx_q] - 1'b1;
                        left_d       = left_q - 6'd1;
                        empty_d      = (left_q == 6'd1);
                        card_d       = CARD_W'(idx_q + 4'd2);
                        state_d      = PRESENT;
                    end else begin
                        idx_d = (idx_q == 4'(RANKS - 1)) ? 4'd0 : (idx_q + 4'd1);
                    end
                end
                PRESENT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (GEN_RES) begin
            state_q  <= IDLE;
            next_c_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= INIT_CNT;
            left_q   <= 6'(DECK_SIZE);
            empty_q  <= 1'b0;
            card_q   <= '0;
        end else begin
            state_q  <= state_d;
            next_c_q <= NEXT_C;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            empty_q  <= empty_d;
            card_q   <= card_d;
        end
    end

    assign CARD     = card_q;
    assign CARD_VLD = (state_q == PRESENT);
    assign BUSY     = (state_q != IDLE);
    assign EMPTY    = empty_q;
    assign LEFT     = left_q;

endmodule

// File: tb/tb_bjack_dealer.sv
// Randomized bench for bjack_dealer: a shoe model predicts every dealt card,
// and a negedge monitor scores CARD_VLD pulses and BUSY/LEFT/EMPTY against it.
module tb_bjack_dealer;

    localparam logic [7:0] SEED = 8'hA5;

    logic       SYS_CLK = 1'b0;
    logic       GEN_RES, NEW_G, NEXT_C;
    logic [3:0] CARD;
    logic       CARD_VLD, BUSY, EMPTY;
    logic [5:0] LEFT;

    bjack_dealer #(.SEED(SEED)) dut (
        .SYS_CLK (SYS_CLK),
        .GEN_RES (GEN_RES),
        .NEW_G   (NEW_G),
        .NEXT_C  (NEXT_C),
        .CARD    (CARD),
        .CARD_VLD(CARD_VLD),
        .BUSY    (BUSY),
        .EMPTY   (EMPTY),
        .LEFT    (LEFT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int card;
        int left;
        int empty;
        int cyc;
    } exp_t;

    exp_t m_q[$];
    int   m_cnt [10];
    int   m_left;
    int   m_prev;
    bit [7:0] m_lfsr;
    int   cyc    = 0;
    int   m_bs   = 0;
    int   m_free = 0;
    int   vld_cnt = 0;
    int   hist [16];

    function automatic bit [7:0] lfsr_next(input bit [7:0] s);
        bit [7:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 8'hB8;
        return n;
    endfunction

    function automatic bit m_idle();
        return cyc >= m_free;
    endfunction

    task automatic restock();
        m_cnt  = '{4, 4, 4, 4, 4, 4, 4, 4, 16, 4};
        m_left = 52;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Shoe model: processes the cycle that ends at this edge.
    bit   edge_c;
    bit [7:0] draw_l;
    int   idx, skips;
    exp_t e;
    always @(posedge SYS_CLK) begin
        edge_c = NEXT_C && !m_prev;
        if (GEN_RES) begin
            restock();
            m_q.delete();
            m_bs   = cyc + 1;
            m_free = cyc + 1;
            m_prev = 0;
            m_lfsr = SEED;
        end else begin
            if (NEW_G) begin
                restock();
                m_q.delete();
                m_bs   = cyc + 1;
                m_free = cyc + 1;
            end else if (edge_c && cyc >= m_free) begin
`ifdef BJACK_DEALER_AUTOFILL_EN
                if (m_left == 0) restock();
`endif
                if (m_left != 0) begin
                    draw_l = lfsr_next(m_lfsr);
                    idx    = draw_l[3:0];
                    if (idx >= 10) idx -= 10;
                    skips = 0;
                    while (m_cnt[idx] == 0) begin
                        idx = (idx + 1) % 10;
                        skips++;
                    end
                    m_cnt[idx]--;
                    m_left--;
                    e.card  = idx + 2;
                    e.left  = m_left;
                    e.empty = (m_left == 0);
                    e.cyc   = cyc + 3 + skips;
                    m_q.push_back(e);
                    m_bs   = cyc + 1;
                    m_free = e.cyc + 1;
                end
            end
            m_prev = NEXT_C;
            m_lfsr = lfsr_next(m_lfsr);
        end
        cyc++;
    end

    // Monitor: compares DUT outputs against the model between edges.
    exp_t got;
    always @(negedge SYS_CLK) begin
        if (!GEN_RES) begin
            chk("busy", BUSY, (cyc >= m_bs && cyc < m_free));
            if (m_idle()) begin
                chk("idle_left", LEFT, m_left);
                chk("idle_empty", EMPTY, (m_left == 0));
            end
            if (m_q.size() > 0 && m_q[0].cyc < cyc) begin
                got = m_q.pop_front();
                chk("missing_vld_at", -1, got.cyc);
            end
            if (CARD_VLD) begin
                vld_cnt++;
                hist[CARD]++;
                if (m_q.size() == 0) begin
                    chk("unexpected_vld_card", CARD, -1);
                end else begin
                    got = m_q.pop_front();
                    chk("vld_cycle", cyc, got.cyc);
                    chk("vld_card", CARD, got.card);
                    chk("vld_left", LEFT, got.left);
                    chk("vld_empty", EMPTY, got.empty);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 60 && !m_idle(); i++) @(negedge SYS_CLK);
        chk("idle_timeout", m_idle(), 1);
    endtask

    task automatic do_req(input bit wait_done);
        @(negedge SYS_CLK);
        NEXT_C = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge SYS_CLK);
        NEXT_C = 1'b0;
        if (wait_done) begin
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge SYS_CLK);
        end
    endtask

    task automatic new_game();
        @(negedge SYS_CLK);
        NEW_G = 1'b1;
        @(negedge SYS_CLK);
        NEW_G = 1'b0;
    endtask

    int v0;
    initial begin
        GEN_RES = 1'b1;
        NEW_G   = 1'b0;
        NEXT_C  = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        chk("rst_card", CARD, 0);
        chk("rst_vld", CARD_VLD, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_empty", EMPTY, 0);
        chk("rst_left", LEFT, 52);
        chk("rst_lfsr", dut.lfsr_w, SEED);
        GEN_RES = 1'b0;

        // Single draw.
        do_req(1'b1);
        chk("first_left", LEFT, 51);
        chk("first_vld_count", vld_cnt, 1);

        // Full shoe of 52 spaced draws.
        new_game();
        vld_cnt = 0;
        for (int i = 0; i < 16; i++) hist[i] = 0;
        for (int i = 0; i < 52; i++) do_req(1'b1);
        chk("deck_vld_count", vld_cnt, 52);
        for (int c = 2; c <= 11; c++)
            chk($sformatf("hist_%0d", c), hist[c], (c == 10) ? 16 : 4);
        chk("deck_left", LEFT, 0);
        chk("deck_empty", EMPTY, 1);

        // Request on an empty shoe.
        do_req(1'b0);
        repeat (20) @(negedge SYS_CLK);
`ifdef BJACK_DEALER_AUTOFILL_EN
        chk("empty_req_vld", vld_cnt, 53);
        chk("empty_req_left", LEFT, 51);
        chk("empty_req_empty", EMPTY, 0);
`else
        chk("empty_req_vld", vld_cnt, 52);
        chk("empty_req_left", LEFT, 0);
        chk("empty_req_empty", EMPTY, 1);
`endif

        // Level held high gives one draw; a pulse while busy is dropped.
        new_game();
        v0 = vld_cnt;
        @(negedge SYS_CLK);
        NEXT_C = 1'b1;
        repeat (40) @(negedge SYS_CLK);
        chk("hold_draws", vld_cnt - v0, 1);
        chk("hold_left", LEFT, 51);
        NEXT_C = 1'b0;
        @(negedge SYS_CLK);
        NEXT_C = 1'b1;
        @(negedge SYS_CLK);
        NEXT_C = 1'b0;
        @(negedge SYS_CLK);
        chk("busy_pulse_busy", BUSY, 1);
        NEXT_C = 1'b1;
        @(negedge SYS_CLK);
        NEXT_C = 1'b0;
        wait_idle();
        repeat (5) @(negedge SYS_CLK);
        chk("busy_pulse_left", LEFT, 50);
        chk("busy_pulse_draws", vld_cnt - v0, 2);

        // Drain the aces so later draws landing on idx 9 must wrap.
        new_game();
        for (int i = 0; i < 52 && m_cnt[9] != 0; i++) do_req(1'b1);
        repeat (8) do_req(1'b1);

        // NEW_G while searching cancels the draw.
        new_game();
        wait_idle();
        @(negedge SYS_CLK);
        NEXT_C = 1'b1;
        @(negedge SYS_CLK);
        NEXT_C = 1'b0;
        @(negedge SYS_CLK);
        chk("search_busy", BUSY, 1);
        NEW_G = 1'b1;
        @(negedge SYS_CLK);
        NEW_G = 1'b0;
        chk("newg_busy", BUSY, 0);
        chk("newg_left", LEFT, 52);
        chk("newg_vld", CARD_VLD, 0);
        repeat (12) @(negedge SYS_CLK);

        // Reset in the middle of a draw.
        do_req(1'b1);
        @(negedge SYS_CLK);
        NEXT_C = 1'b1;
        @(negedge SYS_CLK);
        NEXT_C = 1'b0;
        @(negedge SYS_CLK);
        GEN_RES = 1'b1;
        @(negedge SYS_CLK);
        chk("mid_rst_card", CARD, 0);
        chk("mid_rst_vld", CARD_VLD, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_empty", EMPTY, 0);
        chk("mid_rst_left", LEFT, 52);
        chk("mid_rst_lfsr", dut.lfsr_w, SEED);
        GEN_RES = 1'b0;

        // Random traffic, some requests overlapping busy periods.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) new_game();
            else do_req($urandom_range(0, 3) != 0);
        end
        wait_idle();
        repeat (5) @(negedge SYS_CLK);
        chk("final_queue_empty", m_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
